// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the core-line to host-burst bridge.
package mem_bridge_pkg;

  localparam int unsigned LINE_W    = 128;
  localparam int unsigned BEAT_W    = 16;
  localparam int unsigned BEATS     = 8;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned WDT_LIMIT = 255;
  localparam int unsigned WDT_W     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWbeat,
    StRbeat,
    StDone
  } state_e;

endpackage

// File: rtl/mem_bridge_wdt.sv
// Stall watchdog: counts consecutive active cycles without host progress, raises a sticky error.
module mem_bridge_wdt
  import mem_bridge_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic progress_i,
  output logic timeout_o,
  output logic err_o
);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             stalled;

  always_comb begin
    stalled   = active_i && !progress_i;
    // Fires on the WDT_LIMIT-th consecutive stalled cycle.
    timeout_o = stalled && (cnt_q == WDT_W'(WDT_LIMIT - 1));
    cnt_d     = (stalled && !timeout_o) ? cnt_q + WDT_W'(1) : '0;
    err_d     = err_q | timeout_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mem_line_bridge.sv
// Bridges 128-bit core line fills/evictions onto a 16-bit burst host bus (8 beats per line).
// Define MEM_BRIDGE_WDT_EN to add the stall watchdog and the sticky mem_err output.
module mem_line_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned BEATS     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_request,
  input  logic         mem_rwn,
  input  logic [15:0]  mem_addr,
  input  logic [127:0] mem_write_data,
  output logic         mem_finish,
  output logic [127:0] mem_read_data,
`ifdef MEM_BRIDGE_WDT_EN
  output logic         mem_err,
`endif
  output logic         host_req,
  output logic         host_rwn,
  output logic         host_burst,
  output logic [31:0]  host_addr,
  input  logic         host_ack,
  output logic [1:0]   host_txm,
  output logic [15:0]  host_txd,
  input  logic         host_txd_ack,
  input  logic [15:0]  host_rxd,
  input  logic         host_rxd_vld
);
  import mem_bridge_pkg::*;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                last_beat;
  logic                rwn_q, rwn_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                finish_q, finish_d;
  logic                hreq_q, hreq_d;
  logic                hrwn_q, hrwn_d;
  logic                hburst_q, hburst_d;
  logic [31:0]         haddr_q, haddr_d;
  logic [BEAT_W-1:0]   htxd_q, htxd_d;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[3:0];

`ifdef MEM_BRIDGE_WDT_EN
  logic wdt_active;
  logic wdt_progress;
  logic wdt_timeout;

  assign wdt_active   = (state_q == StCmd) || (state_q == StWbeat) || (state_q == StRbeat);
  assign wdt_progress = ((state_q == StCmd)   && host_ack)     ||
                        ((state_q == StWbeat) && host_txd_ack) ||
                        ((state_q == StRbeat) && host_rxd_vld);

  mem_bridge_wdt u_wdt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .active_i   (wdt_active),
    .progress_i (wdt_progress),
    .timeout_o  (wdt_timeout),
    .err_o      (mem_err)
  );
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rwn_d     = rwn_q;
    line_d    = line_q;
    rdata_d   = rdata_q;
    finish_d  = 1'b0;
    hreq_d    = hreq_q;
    hrwn_d    = hrwn_q;
    hburst_d  = hburst_q;
    haddr_d   = haddr_q;
    htxd_d    = htxd_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    last_beat = (cnt_q == CNT_W'(BEATS - 1));

    unique case (state_q)
      StIdle: begin
        if (mem_request) begin
          rwn_d    = mem_rwn;
          line_d   = mem_write_data;
          hreq_d   = 1'b1;
          hburst_d = 1'b1;
          hrwn_d   = mem_rwn;
          haddr_d  = BASE_ADDR + {16'b0, mem_addr[15:4], 4'b0000};
          state_d  = StCmd;
        end
      end
      StCmd: begin
        // Beat strobes coincident with host_ack are deliberately not looked at here.
        if (host_ack) begin
          hreq_d   = 1'b0;
          hburst_d = 1'b0;
          cnt_d    = '0;
          if (rwn_q) begin
            state_d = StRbeat;
          end else begin
            htxd_d  = line_q[BEAT_W-1:0];
            state_d = StWbeat;
          end
        end
      end
      StWbeat: begin
        if (host_txd_ack) begin
          if (last_beat) begin
            htxd_d   = '0;
            finish_d = 1'b1;
            state_d  = StDone;
          end else begin
            cnt_d  = cnt_inc;
            htxd_d = line_q[{cnt_inc, 4'b0000} +: BEAT_W];
          end
        end
      end
      StRbeat: begin
        if (host_rxd_vld) begin
          line_d[{cnt_q, 4'b0000} +: BEAT_W] = host_rxd;
          if (last_beat) begin
            rdata_d  = line_d;
            finish_d = 1'b1;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StDone: begin
        // mem_request is not sampled here; a held request restarts from idle.
        hrwn_d  = 1'b0;
        haddr_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef MEM_BRIDGE_WDT_EN
    if (wdt_timeout) begin
      hreq_d   = 1'b0;
      hburst_d = 1'b0;
      htxd_d   = '0;
      finish_d = 1'b1;
      state_d  = StDone;
      if (rwn_q) begin
        rdata_d = '1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rwn_q    <= 1'b0;
      line_q   <= '0;
      rdata_q  <= '0;
      finish_q <= 1'b0;
      hreq_q   <= 1'b0;
      hrwn_q   <= 1'b0;
      hburst_q <= 1'b0;
      haddr_q  <= '0;
      htxd_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rwn_q    <= rwn_d;
      line_q   <= line_d;
      rdata_q  <= rdata_d;
      finish_q <= finish_d;
      hreq_q   <= hreq_d;
      hrwn_q   <= hrwn_d;
      hburst_q <= hburst_d;
      haddr_q  <= haddr_d;
      htxd_q   <= htxd_d;
    end
  end

  assign mem_finish    = finish_q;
  assign mem_read_data = rdata_q;
  assign host_req      = hreq_q;
  assign host_rwn      = hrwn_q;
  assign host_burst    = hburst_q;
  assign host_addr     = haddr_q;
  assign host_txd      = htxd_q;
  // Full-line bursts only, so no byte is ever masked.
  assign host_txm      = 2'b00;

endmodule
